// File: rtl/ysyx_25040109_regfile_csr_unit_pkg.sv
// Shared constants for the GPR/CSR unit: CSR addresses and mstatus bit positions.
package ysyx_25040109_regfile_csr_unit_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  // user-level read-only shadows of the machine counters
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Plain writable (non-counter) CSRs; these are the only ones eligible for forwarding.
  function automatic logic csr_is_plain(input logic [11:0] addr);
    return (addr == CSR_MSTATUS) || (addr == CSR_MTVEC) ||
           (addr == CSR_MEPC)    || (addr == CSR_MCAUSE);
  endfunction

endpackage

// File: rtl/ysyx_25040109_csr_counter64.sv
// Two-word free-running counter; a write to either half suppresses that cycle's increment.
module ysyx_25040109_csr_counter64 #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           inc,
  input  logic           we_lo,
  input  logic           we_hi,
  input  logic [W-1:0]   wdata,
  output logic [2*W-1:0] value
);

  logic [2*W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) cnt[W-1:0]   <= wdata;
      if (we_hi) cnt[2*W-1:W] <= wdata;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign value = cnt;

endmodule

// File: rtl/ysyx_25040109_regfile_csr_unit.sv
// GPR file with NUM_RPORTS read ports plus M-mode CSRs, trap entry and mret handling.
// Optional RF_BYPASS_EN: same-cycle write-through forwarding for GPR and plain CSR reads.
module ysyx_25040109_regfile_csr_unit
  import ysyx_25040109_regfile_csr_unit_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 5,
  parameter int          DATA_WIDTH  = 32,
  parameter int          NUM_RPORTS  = 2,
  parameter logic [31:0] MSTATUS_RST = 32'h1800
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen,
  input  logic [ADDR_WIDTH-1:0]            waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0]            a0_out,
  input  logic                             csr_we,
  input  logic [11:0]                      csr_addr,
  input  logic [DATA_WIDTH-1:0]            csr_wdata,
  output logic [DATA_WIDTH-1:0]            csr_rdata,
  input  logic                             trap_valid,
  input  logic [DATA_WIDTH-1:0]            trap_cause,
  input  logic [DATA_WIDTH-1:0]            trap_pc,
  input  logic                             mret_valid,
  input  logic                             instret,
  output logic [DATA_WIDTH-1:0]            mtvec_out,
  output logic [DATA_WIDTH-1:0]            mepc_out
);

  localparam int NREGS = 2 ** ADDR_WIDTH;
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

  // ---------------- GPR array ----------------
  logic [DATA_WIDTH-1:0] gpr [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) gpr[i] <= '0;
    end else if (wen && waddr != '0) begin
      gpr[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = raddr[k*ADDR_WIDTH +: ADDR_WIDTH];
`ifdef RF_BYPASS_EN
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] =
      (ra == '0)               ? '0    :
      (wen && ra == waddr)     ? wdata : gpr[ra];
`else
    assign rdata[k*DATA_WIDTH +: DATA_WIDTH] = (ra == '0) ? '0 : gpr[ra];
`endif
  end

  assign a0_out = gpr[ADDR_WIDTH'(10)];

  // ---------------- CSRs ----------------
  logic [DATA_WIDTH-1:0] mstatus, mtvec, mepc, mcause;
  logic [2*DATA_WIDTH-1:0] mcycle, minstret;

  // Traps and mret pre-empt any software CSR write in the same cycle.
  logic csr_sw;
  assign csr_sw = csr_we && !trap_valid && !mret_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus <= DATA_WIDTH'(MSTATUS_RST);
      mtvec   <= '0;
      mepc    <= '0;
      mcause  <= '0;
    end else if (trap_valid) begin
      mepc                                  <= trap_pc & ALIGN_MASK;
      mcause                                <= trap_cause;
      mstatus[MSTATUS_MPIE]                 <= mstatus[MSTATUS_MIE];
      mstatus[MSTATUS_MIE]                  <= 1'b0;
      mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (mret_valid) begin
      mstatus[MSTATUS_MIE]                  <= mstatus[MSTATUS_MPIE];
      mstatus[MSTATUS_MPIE]                 <= 1'b1;
      mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] <= 2'b11;
    end else if (csr_sw) begin
      case (csr_addr)
        CSR_MSTATUS: mstatus <= csr_wdata;
        CSR_MTVEC:   mtvec   <= csr_wdata;
        CSR_MEPC:    mepc    <= csr_wdata & ALIGN_MASK;
        CSR_MCAUSE:  mcause  <= csr_wdata;
        default: ;
      endcase
    end
  end

  ysyx_25040109_csr_counter64 #(.W(DATA_WIDTH)) u_mcycle (
    .clk   (clk),
    .rst   (rst),
    .inc   (1'b1),
    .we_lo (csr_sw && csr_addr == CSR_MCYCLE),
    .we_hi (csr_sw && csr_addr == CSR_MCYCLEH),
    .wdata (csr_wdata),
    .value (mcycle)
  );

  ysyx_25040109_csr_counter64 #(.W(DATA_WIDTH)) u_minstret (
    .clk   (clk),
    .rst   (rst),
    .inc   (instret),
    .we_lo (csr_sw && csr_addr == CSR_MINSTRET),
    .we_hi (csr_sw && csr_addr == CSR_MINSTRETH),
    .wdata (csr_wdata),
    .value (minstret)
  );

  logic [DATA_WIDTH-1:0] csr_mux;

  always_comb begin
    csr_mux = '0;
    case (csr_addr)
      CSR_MSTATUS:                   csr_mux = mstatus;
      CSR_MTVEC:                     csr_mux = mtvec;
      CSR_MEPC:                      csr_mux = mepc;
      CSR_MCAUSE:                    csr_mux = mcause;
      CSR_MCYCLE,    CSR_CYCLE:      csr_mux = mcycle[DATA_WIDTH-1:0];
      CSR_MCYCLEH,   CSR_CYCLEH:     csr_mux = mcycle[2*DATA_WIDTH-1:DATA_WIDTH];
      CSR_MINSTRET,  CSR_INSTRET:    csr_mux = minstret[DATA_WIDTH-1:0];
      CSR_MINSTRETH, CSR_INSTRETH:   csr_mux = minstret[2*DATA_WIDTH-1:DATA_WIDTH];
      default:                       csr_mux = '0;
    endcase
  end

`ifdef RF_BYPASS_EN
  // Forward the value that will actually land, so mepc shows its aligned form.
  always_comb begin
    csr_rdata = csr_mux;
    if (csr_sw && csr_is_plain(csr_addr))
      csr_rdata = (csr_addr == CSR_MEPC) ? (csr_wdata & ALIGN_MASK) : csr_wdata;
  end
`else
  assign csr_rdata = csr_mux;
`endif

  assign mtvec_out = mtvec;
  assign mepc_out  = mepc;

endmodule
